// File: rtl/lsu_subword_rmw.sv
// Load/store unit: sign/zero-extended loads, SW direct, SB/SH via registered read-modify-write.
// Latency: loads and SW combinational (0 cycles); SB/SH take 2 cycles (IDLE merge, WRITE commit).
// Backpressure: Stall=1 in the IDLE cycle of a sub-word store; optional trap via LSU_MISALIGN_TRAP_EN.
module lsu_subword_rmw #(
    parameter int WORD_IDX_BITS = 7,
    parameter int ADDR_LSB      = 2
) (
    input  logic        Clk,
    input  logic        Rst,
    input  logic        Mem_Read,
    input  logic        Mem_Write,
    input  logic [2:0]  Funct3,
    input  logic [31:0] Addr,
    input  logic [31:0] Store_Data,
    output logic [31:0] Load_Data,
    output logic        Stall,
    output logic        Misaligned,
    output logic [31:0] Mem_Addr,
    output logic [31:0] Mem_WData,
    output logic        Mem_WE,
    input  logic [31:0] Mem_RData
);

    localparam int IDX_HI = ADDR_LSB + WORD_IDX_BITS - 1;

    typedef enum logic {IDLE, WRITE} state_t;

    state_t      state_q, state_d;
    logic [31:0] hold_addr_q, hold_addr_d;
    logic [31:0] hold_word_q, hold_word_d;

    logic        is_byte, is_half, is_word, is_unsigned;
    logic        mis_acc;
    logic [4:0]  byte_sh, half_sh;
    logic [31:0] rd_byte_shifted, rd_half_shifted;
    logic [31:0] merged_word, load_ext;
    logic [31:0] addr_pass;

    // Decode width/sign and lane shift amounts; build the extended load and merged store word.
    always_comb begin
        is_byte     = (Funct3 == 3'b000) || (Funct3 == 3'b100);
        is_half     = (Funct3 == 3'b001) || (Funct3 == 3'b101);
        is_word     = (Funct3 == 3'b010);
        is_unsigned = Funct3[2];
        byte_sh     = {Addr[1:0], 3'b000};
        half_sh     = {Addr[1], 4'b0000};
        // Word-index field and the bits around it all pass straight through.
        addr_pass   = {Addr[31:IDX_HI+1], Addr[IDX_HI:ADDR_LSB], Addr[ADDR_LSB-1:0]};
`ifdef LSU_MISALIGN_TRAP_EN
        mis_acc     = (Mem_Read || Mem_Write) &&
                      ((is_half && Addr[0]) || (is_word && (Addr[1:0] != 2'b00)));
`else
        mis_acc     = 1'b0;
`endif
        rd_byte_shifted = Mem_RData >> byte_sh;
        rd_half_shifted = Mem_RData >> half_sh;
        load_ext = 32'h0;
        if (is_byte) begin
            load_ext = is_unsigned ? {24'h0, rd_byte_shifted[7:0]}
                                   : {{24{rd_byte_shifted[7]}}, rd_byte_shifted[7:0]};
        end else if (is_half) begin
            load_ext = is_unsigned ? {16'h0, rd_half_shifted[15:0]}
                                   : {{16{rd_half_shifted[15]}}, rd_half_shifted[15:0]};
        end else if (is_word) begin
            load_ext = Mem_RData;
        end
        if (is_byte) begin
            merged_word = (Mem_RData & ~(32'h0000_00FF << byte_sh)) |
                          ({24'h0, Store_Data[7:0]} << byte_sh);
        end else begin
            merged_word = (Mem_RData & ~(32'h0000_FFFF << half_sh)) |
                          ({16'h0, Store_Data[15:0]} << half_sh);
        end
    end

    // Next-state and output logic; write enable is always gated by reset.
    always_comb begin
        state_d     = state_q;
        hold_addr_d = hold_addr_q;
        hold_word_d = hold_word_q;
        Load_Data   = 32'h0;
        Stall       = 1'b0;
        Misaligned  = 1'b0;
        Mem_Addr    = addr_pass;
        Mem_WData   = Store_Data;
        Mem_WE      = 1'b0;
        case (state_q)
            IDLE: begin
                Misaligned = mis_acc;
                if (Mem_Write) begin
                    if (!mis_acc && is_word) begin
                        Mem_WE = ~Rst;
                    end else if (!mis_acc && (is_byte || is_half)) begin
                        // Merge is registered to keep memory read->write off one path.
                        Stall       = 1'b1;
                        hold_word_d = merged_word;
                        hold_addr_d = addr_pass;
                        state_d     = WRITE;
                    end
                end else if (Mem_Read && !mis_acc) begin
                    Load_Data = load_ext;
                end
            end
            WRITE: begin
                Mem_Addr  = hold_addr_q;
                Mem_WData = hold_word_q;
                Mem_WE    = ~Rst;
                state_d   = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // State and RMW holding registers with synchronous reset.
    always_ff @(posedge Clk) begin
        if (Rst) begin
            state_q     <= IDLE;
            hold_addr_q <= 32'h0;
            hold_word_q <= 32'h0;
        end else begin
            state_q     <= state_d;
            hold_addr_q <= hold_addr_d;
            hold_word_q <= hold_word_d;
        end
    end

endmodule

// File: tb/tb_lsu_subword_rmw.sv
// Bench for lsu_subword_rmw: word memory model driven by the DUT, byte-array reference model.
// Latency: checks combinational outputs mid-cycle, RMW commit one cycle later.
// Backpressure: core inputs held while Stall=1, as the core would.
module tb_lsu_subword_rmw;

    logic        Clk = 1'b0;
    logic        Rst;
    logic        Mem_Read, Mem_Write;
    logic [2:0]  Funct3;
    logic [31:0] Addr, Store_Data;
    logic [31:0] Load_Data;
    logic        Stall, Misaligned;
    logic [31:0] Mem_Addr, Mem_WData;
    logic        Mem_WE;
    logic [31:0] Mem_RData;

    int checks = 0;
    int failures = 0;

    logic [31:0] mem [128];
    logic [7:0]  ref_mem [512];

    always #5 Clk = ~Clk;

    lsu_subword_rmw dut (
        .Clk(Clk), .Rst(Rst), .Mem_Read(Mem_Read), .Mem_Write(Mem_Write),
        .Funct3(Funct3), .Addr(Addr), .Store_Data(Store_Data),
        .Load_Data(Load_Data), .Stall(Stall), .Misaligned(Misaligned),
        .Mem_Addr(Mem_Addr), .Mem_WData(Mem_WData), .Mem_WE(Mem_WE),
        .Mem_RData(Mem_RData)
    );

    // Word-only data memory: combinational read, write at the clock edge.
    assign Mem_RData = mem[Mem_Addr[8:2]];
    always @(posedge Clk) if (Mem_WE) mem[Mem_Addr[8:2]] <= Mem_WData;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    function automatic int width_of(input logic [2:0] f3);
        case (f3)
            3'd0, 3'd4: return 1;
            3'd1, 3'd5: return 2;
            3'd2:       return 4;
            default:    return 0;
        endcase
    endfunction

    function automatic logic is_mis(input logic [2:0] f3, input logic [31:0] a);
`ifdef LSU_MISALIGN_TRAP_EN
        int n = width_of(f3);
        return (n == 2 && a[0]) || (n == 4 && a[1:0] != 2'b00);
`else
        return 1'b0;
`endif
    endfunction

    function automatic logic [31:0] ref_word(input int a);
        int b = a - (a % 4);
        return {ref_mem[b+3], ref_mem[b+2], ref_mem[b+1], ref_mem[b]};
    endfunction

    function automatic logic [31:0] ref_load(input logic [2:0] f3, input logic [31:0] a);
        int n = width_of(f3);
        int base;
        longint v = 0;
        if (n == 0 || is_mis(f3, a)) return 32'h0;
        base = int'(a[8:0]) - (int'(a[8:0]) % n);
        for (int i = n - 1; i >= 0; i--) v = v * 256 + ref_mem[base+i];
        if (!f3[2] && n < 4 && v >= (longint'(1) << (8*n - 1))) v = v - (longint'(1) << (8*n));
        return 32'(v);
    endfunction

    task automatic ref_store(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] d);
        int n = width_of(f3);
        int base;
        logic [31:0] dd = d;
        if (n == 0 || is_mis(f3, a)) return;
        base = int'(a[8:0]) - (int'(a[8:0]) % n);
        for (int i = 0; i < n; i++) begin
            ref_mem[base+i] = dd[7:0];
            dd = dd >> 8;
        end
    endtask

    task automatic set_idle();
        Mem_Read = 0; Mem_Write = 0; Funct3 = 3'd0; Addr = 32'h0; Store_Data = 32'h0;
    endtask

    // One load cycle: result must be valid in the same cycle.
    task automatic do_load(input logic [2:0] f3, input logic [31:0] a);
        Mem_Read = 1; Mem_Write = 0; Funct3 = f3; Addr = a; Store_Data = $urandom;
        #2;
        check("ld_data", Load_Data, ref_load(f3, a));
        check("ld_stall", {31'h0, Stall}, 32'h0);
        check("ld_we", {31'h0, Mem_WE}, 32'h0);
        check("ld_mis", {31'h0, Misaligned}, {31'h0, is_mis(f3, a)});
        check("ld_addr", Mem_Addr, a);
        @(posedge Clk); #1;
        set_idle();
    endtask

    // A store (optionally with Mem_Read also high); follows SW / RMW / no-op paths.
    task automatic do_store(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] d,
                            input logic also_rd);
        int n = width_of(f3);
        logic [31:0] expw;
        Mem_Read = also_rd; Mem_Write = 1; Funct3 = f3; Addr = a; Store_Data = d;
        #2;
        check("st_mis", {31'h0, Misaligned}, {31'h0, is_mis(f3, a)});
        check("st_ld0", Load_Data, 32'h0);
        if (n == 0 || is_mis(f3, a)) begin
            check("st_nop_we", {31'h0, Mem_WE}, 32'h0);
            check("st_nop_stall", {31'h0, Stall}, 32'h0);
            @(posedge Clk); #1;
        end else if (n == 4) begin
            ref_store(f3, a, d);
            check("sw_we", {31'h0, Mem_WE}, 32'h1);
            check("sw_stall", {31'h0, Stall}, 32'h0);
            check("sw_wdata", Mem_WData, ref_word(int'(a[8:0])));
            @(posedge Clk); #1;
        end else begin
            ref_store(f3, a, d);
            expw = ref_word(int'(a[8:0]));
            check("rmw1_stall", {31'h0, Stall}, 32'h1);
            check("rmw1_we", {31'h0, Mem_WE}, 32'h0);
            @(posedge Clk); #2;
            check("rmw2_we", {31'h0, Mem_WE}, 32'h1);
            check("rmw2_stall", {31'h0, Stall}, 32'h0);
            check("rmw2_wdata", Mem_WData, expw);
            check("rmw2_addr", {23'h0, Mem_Addr[8:0]}, {23'h0, a[8:0]});
            @(posedge Clk); #1;
        end
        set_idle();
    endtask

    initial begin
        logic [2:0] st_codes [6];
        st_codes[0] = 3'd0; st_codes[1] = 3'd1; st_codes[2] = 3'd2;
        st_codes[3] = 3'd3; st_codes[4] = 3'd6; st_codes[5] = 3'd7;
        Rst = 1;
        set_idle();
        repeat (2) @(posedge Clk);
        #1;
        check("rst_stall", {31'h0, Stall}, 32'h0);
        check("rst_we", {31'h0, Mem_WE}, 32'h0);
        check("rst_ld", Load_Data, 32'h0);
        check("rst_mis", {31'h0, Misaligned}, 32'h0);
        @(posedge Clk); #1;
        Rst = 0;

        // Clear the whole memory through the DUT.
        for (int i = 0; i < 128; i++) do_store(3'd2, 32'(i * 4), 32'h0, 1'b0);

        // Directed plan.
        do_store(3'd2, 32'h10, 32'h8765_4321, 1'b0);
        do_load(3'd2, 32'h10);
        check("lw_10", ref_load(3'd2, 32'h10), 32'h8765_4321);
        do_store(3'd2, 32'h20, 32'hAABB_CCDD, 1'b0);
        do_store(3'd0, 32'h21, 32'h0000_0011, 1'b0);
        check("sb_word", mem[8], 32'hAABB_11DD);
        do_load(3'd4, 32'h21);
        do_load(3'd0, 32'h23);
        check("lb_23", ref_load(3'd0, 32'h23), 32'hFFFF_FFAA);
        do_store(3'd1, 32'h22, 32'h1234_BEEF, 1'b0);
        check("sh_word", mem[8], 32'hBEEF_11DD);
        do_store(3'd2, 32'h24, 32'h0, 1'b0);
        do_store(3'd1, 32'h26, 32'h1234_BEEF, 1'b0);
        check("sh_zero_word", mem[9], 32'hBEEF_0000);
        do_load(3'd1, 32'h26);
        do_load(3'd5, 32'h26);

        // Reset arriving in WRITE drops the pending write.
        do_store(3'd2, 32'h50, 32'h1122_3344, 1'b0);
        Mem_Write = 1; Funct3 = 3'd0; Addr = 32'h51; Store_Data = 32'h99;
        #2;
        check("rstw_stall1", {31'h0, Stall}, 32'h1);
        @(posedge Clk); #1;
        Rst = 1;
        #1;
        check("rstw_we", {31'h0, Mem_WE}, 32'h0);
        @(posedge Clk); #1;
        Rst = 0;
        set_idle();
        #1;
        check("rstw_stall", {31'h0, Stall}, 32'h0);
        check("rstw_mem", mem[20], 32'h1122_3344);
        @(posedge Clk); #1;
        do_load(3'd2, 32'h50);

        // Back-to-back sub-word stores.
        do_store(3'd0, 32'h30, 32'h01, 1'b0);
        do_store(3'd0, 32'h31, 32'h02, 1'b0);
        check("b2b_word", mem[12], 32'h0000_0201);

        // Misaligned word store, store+read priority, invalid codes.
        do_store(3'd2, 32'h42, 32'hCAFE_F00D, 1'b0);
        do_load(3'd2, 32'h40);
        do_store(3'd2, 32'h60, 32'h5A5A_A5A5, 1'b1);
        do_store(3'd3, 32'h64, 32'hFFFF_FFFF, 1'b0);
        do_load(3'd7, 32'h60);

        // Randomized mix against the byte-level model.
        for (int k = 0; k < 300; k++) begin
            int kind = $urandom_range(0, 2);
            logic [31:0] a = 32'($urandom_range(0, 511));
            if (kind == 0) begin
                do_load(3'($urandom_range(0, 7)), a);
            end else if (kind == 1) begin
                do_store(st_codes[$urandom_range(0, 5)], a, $urandom, 1'($urandom_range(0, 1)));
            end else begin
                Addr = a;
                #2;
                check("idle_stall", {31'h0, Stall}, 32'h0);
                check("idle_we", {31'h0, Mem_WE}, 32'h0);
                check("idle_ld", Load_Data, 32'h0);
                @(posedge Clk); #1;
                set_idle();
            end
        end

        for (int i = 0; i < 128; i++) check("final_mem", mem[i], ref_word(i * 4));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
